// File: rtl/sdram_responder.sv
// -----------------------------------------------------------------------------
// sdram_responder
//
// Behavioural SDRAM device model that responds to a controller's command bus.
// It decodes the SDRAM command pins and tracks the init sequence (precharge-all
// followed by a mode register load). It also tracks per-bank open rows and
// tRCD timing. Words live in a small internal array. Reads return data after
// the programmed CAS latency. Protocol violations are reported as coded errors.
//
// Ports
//   clk, reset        : single clock; synchronous active-high reset
//   SDRAM_A/BA        : address and bank (13 / 2 bits)
//   SDRAM_nCS/nRAS/nCAS/nWE : command strobes, active low
//   SDRAM_DQML/DQMH   : write byte masks (1 = keep that byte)
//   dq_in             : write data, sampled with the WRITE command
//   dq_out, dq_oe     : read data and its one-cycle valid / drive enable
//   init_done         : device has completed its init sequence
//   bank_open         : one bit per bank, 1 while that bank has an open row
//   cas_lat           : current CAS latency (2 or 3)
//   refresh_cnt       : number of accepted AUTO_REFRESH commands (wraps)
//   err_pulse/err_code/err_flag : last error, one-cycle strobe, sticky flag
//
// Error codes: 1 command before init, 2 ACTIVE on open bank, 3 access to idle
// bank, 4 tRCD violation, 5 refresh with open bank, 6 mode load with open
// bank, 7 illegal mode value.
// -----------------------------------------------------------------------------
module sdram_responder #(
  parameter int ROW_BITS = 3,
  parameter int COL_BITS = 9,
  parameter int TRCD     = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [12:0] SDRAM_A,
  input  logic [1:0]  SDRAM_BA,
  input  logic        SDRAM_nCS,
  input  logic        SDRAM_nRAS,
  input  logic        SDRAM_nCAS,
  input  logic        SDRAM_nWE,
  input  logic        SDRAM_DQML,
  input  logic        SDRAM_DQMH,
  input  logic [15:0] dq_in,
  output logic [15:0] dq_out,
  output logic        dq_oe,
  output logic        init_done,
  output logic [3:0]  bank_open,
  output logic [1:0]  cas_lat,
  output logic [15:0] refresh_cnt,
  output logic        err_pulse,
  output logic        err_flag,
  output logic [3:0]  err_code
);

  localparam int IDX_BITS = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH    = 1 << IDX_BITS;
  localparam int CNT_BITS = (TRCD > 1) ? $clog2(TRCD) : 1;

  typedef enum logic [1:0] {
    ST_UNINIT,
    ST_PRECHARGED,
    ST_READY
  } init_state_t;

  typedef enum logic [2:0] {
    CMD_NOP,
    CMD_ACTIVE,
    CMD_READ,
    CMD_WRITE,
    CMD_PRECHARGE,
    CMD_REFRESH,
    CMD_LOAD_MODE
  } cmd_t;

  init_state_t               r_state, w_state_next;
  cmd_t                      w_cmd;

  logic [3:0]                r_bank_act;
  logic [ROW_BITS-1:0]       r_row  [4];
  logic [CNT_BITS-1:0]       r_trcd [4];

  logic [15:0]               r_mem [DEPTH];
  logic [15:0]               r_rd_word;

  // Read pipeline: stage 0 holds the word fetched on the READ edge; stage 1
  // adds one more cycle for CAS latency 3.
  logic                      r_p0_vld, r_p0_cl3;
  logic                      r_p1_vld;
  logic [15:0]               r_p1_data;

  logic [1:0]                r_cas_lat;
  logic [15:0]               r_refresh_cnt;
  logic                      r_err_pulse, r_err_flag;
  logic [3:0]                r_err_code;
  logic [15:0]               r_dq_out;
  logic                      r_dq_oe;

  logic                      w_err;
  logic [3:0]                w_err_code;
  logic                      w_do_act, w_do_read, w_do_write, w_do_ref, w_do_mode;
  logic                      w_close_all, w_close_one;
  logic                      w_bank_active, w_any_open, w_a10, w_mode_ok;
  logic [IDX_BITS-1:0]       w_idx;
  logic                      w_unused;

  // Only a subset of address bits reaches the storage index; the rest alias.
  assign w_unused = &{1'b0, SDRAM_A};

  assign w_bank_active = r_bank_act[SDRAM_BA];
  assign w_any_open    = |r_bank_act;
  assign w_a10         = SDRAM_A[10];
  // Burst length 1, sequential, CL 2 or 3 is the only accepted mode.
  assign w_mode_ok     = ((SDRAM_A[6:4] == 3'd2) || (SDRAM_A[6:4] == 3'd3)) &&
                         (SDRAM_A[3:0] == 4'd0);
  assign w_idx         = {SDRAM_BA, r_row[SDRAM_BA], SDRAM_A[COL_BITS-1:0]};

  // Command decode; a deselected chip and BURST_TERMINATE both act as NOP.
  always_comb begin
    w_cmd = CMD_NOP;
    if (!SDRAM_nCS) begin
      case ({SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE})
        3'b011:  w_cmd = CMD_ACTIVE;
        3'b101:  w_cmd = CMD_READ;
        3'b100:  w_cmd = CMD_WRITE;
        3'b010:  w_cmd = CMD_PRECHARGE;
        3'b001:  w_cmd = CMD_REFRESH;
        3'b000:  w_cmd = CMD_LOAD_MODE;
        default: w_cmd = CMD_NOP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_UNINIT;
    else       r_state <= w_state_next;
  end

  // Next-state and per-command decisions.
  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_err        = 1'b0;
    w_err_code   = 4'd0;
    w_do_act     = 1'b0;
    w_do_read    = 1'b0;
    w_do_write   = 1'b0;
    w_do_ref     = 1'b0;
    w_do_mode    = 1'b0;
    w_close_all  = 1'b0;
    w_close_one  = 1'b0;
    case (w_cmd)
      CMD_ACTIVE: begin
        if (r_state != ST_READY) begin
          w_err = 1'b1; w_err_code = 4'd1;
        end else if (w_bank_active) begin
          w_err = 1'b1; w_err_code = 4'd2;
        end else begin
          w_do_act = 1'b1;
        end
      end
      CMD_READ, CMD_WRITE: begin
        if (r_state != ST_READY) begin
          w_err = 1'b1; w_err_code = 4'd1;
        end else if (!w_bank_active) begin
          w_err = 1'b1; w_err_code = 4'd3;
        end else begin
          // Early access is flagged but still carried out.
          if (r_trcd[SDRAM_BA] != '0) begin
            w_err = 1'b1; w_err_code = 4'd4;
          end
          w_do_read   = (w_cmd == CMD_READ);
          w_do_write  = (w_cmd == CMD_WRITE);
          w_close_one = w_a10;
        end
      end
      CMD_REFRESH: begin
        if (r_state != ST_READY) begin
          w_err = 1'b1; w_err_code = 4'd1;
        end else if (w_any_open) begin
          w_err = 1'b1; w_err_code = 4'd5;
        end else begin
          w_do_ref = 1'b1;
        end
      end
      CMD_PRECHARGE: begin
        if (w_a10) begin
          w_close_all = 1'b1;
          if (r_state == ST_UNINIT) w_state_next = ST_PRECHARGED;
        end else begin
          w_close_one = 1'b1;
        end
      end
      CMD_LOAD_MODE: begin
        if (w_any_open) begin
          w_err = 1'b1; w_err_code = 4'd6;
        end else if (!w_mode_ok) begin
          w_err = 1'b1; w_err_code = 4'd7;
        end else begin
          w_do_mode = 1'b1;
          if (r_state == ST_PRECHARGED) w_state_next = ST_READY;
        end
      end
      default: ;
    endcase
  end

  // Bank state: open flag, latched row and tRCD countdown.
  // NOTE: state registers use non-blocking assignment so every register sees
  // the pre-edge values; later assignments in the block take priority.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bank_act <= '0;
      for (int b = 0; b < 4; b++) begin
        r_row[b]  <= '0;
        r_trcd[b] <= '0;
      end
    end else begin
      for (int b = 0; b < 4; b++) begin
        if (r_trcd[b] != '0) r_trcd[b] <= r_trcd[b] - 1'b1;
      end
      if (w_do_act) begin
        r_bank_act[SDRAM_BA] <= 1'b1;
        r_row[SDRAM_BA]      <= SDRAM_A[ROW_BITS-1:0];
        r_trcd[SDRAM_BA]     <= CNT_BITS'(TRCD - 1);
      end
      if (w_close_all) r_bank_act <= '0;
      if (w_close_one) r_bank_act[SDRAM_BA] <= 1'b0;
    end
  end

  // NOTE: the storage array has no reset; contents survive reset and the
  // array maps onto plain RAM with a registered read port.
  always_ff @(posedge clk) begin
    if (!reset && w_do_write) begin
      if (!SDRAM_DQML) r_mem[w_idx][7:0]  <= dq_in[7:0];
      if (!SDRAM_DQMH) r_mem[w_idx][15:8] <= dq_in[15:8];
    end
    r_rd_word <= r_mem[w_idx];
  end

  // Read return pipeline. The latency is captured per READ, so a later mode
  // change cannot disturb a read already in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_p0_vld  <= 1'b0;
      r_p0_cl3  <= 1'b0;
      r_p1_vld  <= 1'b0;
      r_p1_data <= '0;
      r_dq_oe   <= 1'b0;
      r_dq_out  <= '0;
    end else begin
      r_p0_vld  <= w_do_read;
      r_p0_cl3  <= (r_cas_lat == 2'd3);
      r_p1_vld  <= r_p0_vld && r_p0_cl3;
      r_p1_data <= r_rd_word;
      r_dq_oe   <= 1'b0;
      r_dq_out  <= '0;
      if (r_p0_vld && !r_p0_cl3) begin
        r_dq_oe  <= 1'b1;
        r_dq_out <= r_rd_word;
      end
      if (r_p1_vld) begin
        r_dq_oe  <= 1'b1;
        r_dq_out <= r_p1_data;
      end
    end
  end

  // Mode, refresh counter and error reporting.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cas_lat     <= 2'd3;
      r_refresh_cnt <= '0;
      r_err_pulse   <= 1'b0;
      r_err_flag    <= 1'b0;
      r_err_code    <= '0;
    end else begin
      if (w_do_mode) r_cas_lat     <= SDRAM_A[5:4];
      if (w_do_ref)  r_refresh_cnt <= r_refresh_cnt + 16'd1;
      r_err_pulse <= w_err;
      if (w_err) begin
        r_err_code <= w_err_code;
        r_err_flag <= 1'b1;
      end
    end
  end

  assign dq_out      = r_dq_out;
  assign dq_oe       = r_dq_oe;
  assign init_done   = (r_state == ST_READY);
  assign bank_open   = r_bank_act;
  assign cas_lat     = r_cas_lat;
  assign refresh_cnt = r_refresh_cnt;
  assign err_pulse   = r_err_pulse;
  assign err_flag    = r_err_flag;
  assign err_code    = r_err_code;

endmodule

// File: tb/tb_sdram_responder.sv
// -----------------------------------------------------------------------------
// tb_sdram_responder
//
// Directed bench for sdram_responder. A table of one-cycle command vectors,
// each with hand-computed expected outputs, covers init, errors, masking,
// auto-precharge, tRCD, refresh and the CL3 read pipeline. Hand-written
// sequences then cover reset during a read and refresh counter wrap.
// -----------------------------------------------------------------------------
module tb_sdram_responder;

  localparam logic [2:0] C_NOP = 3'b111;
  localparam logic [2:0] C_ACT = 3'b011;
  localparam logic [2:0] C_RD  = 3'b101;
  localparam logic [2:0] C_WR  = 3'b100;
  localparam logic [2:0] C_BT  = 3'b110;
  localparam logic [2:0] C_PRE = 3'b010;
  localparam logic [2:0] C_REF = 3'b001;
  localparam logic [2:0] C_LM  = 3'b000;

  logic        clk = 1'b0;
  logic        reset;
  logic [12:0] SDRAM_A;
  logic [1:0]  SDRAM_BA;
  logic        SDRAM_nCS, SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE;
  logic        SDRAM_DQML, SDRAM_DQMH;
  logic [15:0] dq_in;
  logic [15:0] dq_out;
  logic        dq_oe;
  logic        init_done;
  logic [3:0]  bank_open;
  logic [1:0]  cas_lat;
  logic [15:0] refresh_cnt;
  logic        err_pulse, err_flag;
  logic [3:0]  err_code;

  always #5 clk = ~clk;

  sdram_responder dut (
    .clk         (clk),
    .reset       (reset),
    .SDRAM_A     (SDRAM_A),
    .SDRAM_BA    (SDRAM_BA),
    .SDRAM_nCS   (SDRAM_nCS),
    .SDRAM_nRAS  (SDRAM_nRAS),
    .SDRAM_nCAS  (SDRAM_nCAS),
    .SDRAM_nWE   (SDRAM_nWE),
    .SDRAM_DQML  (SDRAM_DQML),
    .SDRAM_DQMH  (SDRAM_DQMH),
    .dq_in       (dq_in),
    .dq_out      (dq_out),
    .dq_oe       (dq_oe),
    .init_done   (init_done),
    .bank_open   (bank_open),
    .cas_lat     (cas_lat),
    .refresh_cnt (refresh_cnt),
    .err_pulse   (err_pulse),
    .err_flag    (err_flag),
    .err_code    (err_code)
  );

  typedef struct packed {
    logic        ep;
    logic [3:0]  ec;
    logic        ef;
    logic        id;
    logic [3:0]  bo;
    logic [1:0]  cl;
    logic [15:0] rc;
    logic        oe;
    logic [15:0] dout;
  } obs_t;

  typedef struct {
    logic        ncs;
    logic [2:0]  cmd;
    logic [1:0]  ba;
    logic [12:0] a;
    logic [15:0] dq;
    logic [1:0]  dqm;   // {DQMH, DQML}
    obs_t        exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_bad = 0;

  function automatic obs_t mk(logic ep, logic [3:0] ec, logic ef, logic id,
                              logic [3:0] bo, logic [1:0] cl, logic [15:0] rc,
                              logic oe, logic [15:0] dout);
    obs_t o;
    o.ep = ep; o.ec = ec; o.ef = ef; o.id = id; o.bo = bo;
    o.cl = cl; o.rc = rc; o.oe = oe; o.dout = dout;
    return o;
  endfunction

  function automatic obs_t sample();
    return mk(err_pulse, err_code, err_flag, init_done, bank_open, cas_lat,
              refresh_cnt, dq_oe, dq_out);
  endfunction

  function automatic string fmt(obs_t o);
    return $sformatf("ep=%0d ec=%0d ef=%0d id=%0d bo=%h cl=%0d rc=%h oe=%0d dq=%h",
                     o.ep, o.ec, o.ef, o.id, o.bo, o.cl, o.rc, o.oe, o.dout);
  endfunction

  task automatic check(string name, obs_t act, obs_t exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {%s} expected {%s}", name, fmt(act), fmt(exp));
    end
  endtask

  task automatic drive(logic ncs, logic [2:0] cmd, logic [1:0] ba,
                       logic [12:0] a, logic [15:0] dq, logic [1:0] dqm);
    SDRAM_nCS = ncs;
    {SDRAM_nRAS, SDRAM_nCAS, SDRAM_nWE} = cmd;
    SDRAM_BA  = ba;
    SDRAM_A   = a;
    dq_in     = dq;
    {SDRAM_DQMH, SDRAM_DQML} = dqm;
  endtask

  // One command per clock; outputs are sampled 1 ns after the edge.
  task automatic stepc(string name, logic [2:0] cmd, logic [1:0] ba,
                       logic [12:0] a, logic [15:0] dq, logic [1:0] dqm,
                       obs_t exp);
    drive(1'b0, cmd, ba, a, dq, dqm);
    @(posedge clk); #1;
    check(name, sample(), exp);
  endtask

  task automatic add(logic ncs, logic [2:0] cmd, logic [1:0] ba,
                     logic [12:0] a, logic [15:0] dq, logic [1:0] dqm,
                     obs_t exp);
    vec_t v;
    v.ncs = ncs; v.cmd = cmd; v.ba = ba; v.a = a; v.dq = dq; v.dqm = dqm;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  initial begin
    // ---------------- vector table (expected values hand-computed) --------
    add(1, C_ACT, 0, 13'h000, 16'h0, 2'b00, mk(0,0,0,0,4'h0,3,16'h0,0,16'h0)); // deselected
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,0,0,0,4'h0,3,16'h0,0,16'h0));
    add(0, C_ACT, 0, 13'h000, 16'h0, 2'b00, mk(1,1,1,0,4'h0,3,16'h0,0,16'h0)); // before init
    add(0, C_RD,  0, 13'h000, 16'h0, 2'b00, mk(1,1,1,0,4'h0,3,16'h0,0,16'h0));
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,1,1,0,4'h0,3,16'h0,0,16'h0));
    add(0, C_PRE, 0, 13'h400, 16'h0, 2'b00, mk(0,1,1,0,4'h0,3,16'h0,0,16'h0)); // -> PRECHARGED
    add(0, C_REF, 0, 13'h000, 16'h0, 2'b00, mk(1,1,1,0,4'h0,3,16'h0,0,16'h0));
    add(0, C_LM,  0, 13'h028, 16'h0, 2'b00, mk(1,7,1,0,4'h0,3,16'h0,0,16'h0)); // A3=1
    add(0, C_LM,  0, 13'h010, 16'h0, 2'b00, mk(1,7,1,0,4'h0,3,16'h0,0,16'h0)); // CL1
    add(0, C_LM,  0, 13'h021, 16'h0, 2'b00, mk(1,7,1,0,4'h0,3,16'h0,0,16'h0)); // BL!=1
    add(0, C_LM,  0, 13'h020, 16'h0, 2'b00, mk(0,7,1,1,4'h0,2,16'h0,0,16'h0)); // READY, CL2
    add(0, C_ACT, 1, 13'h1FFD,16'h0, 2'b00, mk(0,7,1,1,4'h2,2,16'h0,0,16'h0)); // row 5 aliased
    add(0, C_BT,  0, 13'h000, 16'h0, 2'b00, mk(0,7,1,1,4'h2,2,16'h0,0,16'h0));
    add(0, C_WR,  1, 13'h1A4, 16'h0000, 2'b00, mk(0,7,1,1,4'h2,2,16'h0,0,16'h0));
    add(0, C_WR,  1, 13'h1A4, 16'hBEEF, 2'b01, mk(0,7,1,1,4'h2,2,16'h0,0,16'h0)); // DQML=1
    add(0, C_RD,  1, 13'h1A4, 16'h0, 2'b00, mk(0,7,1,1,4'h2,2,16'h0,0,16'h0));
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,7,1,1,4'h2,2,16'h0,1,16'hBE00));
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,7,1,1,4'h2,2,16'h0,0,16'h0));
    add(0, C_ACT, 1, 13'h002, 16'h0, 2'b00, mk(1,2,1,1,4'h2,2,16'h0,0,16'h0)); // already open
    add(0, C_WR,  1, 13'h1A4, 16'h5577, 2'b10, mk(0,2,1,1,4'h2,2,16'h0,0,16'h0)); // DQMH=1
    add(0, C_RD,  1, 13'h5A4, 16'h0, 2'b11, mk(0,2,1,1,4'h0,2,16'h0,0,16'h0)); // auto-precharge
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,2,1,1,4'h0,2,16'h0,1,16'hBE77));
    add(0, C_RD,  1, 13'h1A4, 16'h0, 2'b00, mk(1,3,1,1,4'h0,2,16'h0,0,16'h0)); // idle bank
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,3,1,1,4'h0,2,16'h0,0,16'h0));
    add(0, C_WR,  3, 13'h000, 16'h0, 2'b00, mk(1,3,1,1,4'h0,2,16'h0,0,16'h0));
    add(0, C_ACT, 0, 13'h000, 16'h0, 2'b00, mk(0,3,1,1,4'h1,2,16'h0,0,16'h0));
    add(0, C_REF, 0, 13'h000, 16'h0, 2'b00, mk(1,5,1,1,4'h1,2,16'h0,0,16'h0)); // bank open
    add(0, C_LM,  0, 13'h030, 16'h0, 2'b00, mk(1,6,1,1,4'h1,2,16'h0,0,16'h0)); // bank open
    add(0, C_PRE, 0, 13'h000, 16'h0, 2'b00, mk(0,6,1,1,4'h0,2,16'h0,0,16'h0));
    add(0, C_PRE, 2, 13'h000, 16'h0, 2'b00, mk(0,6,1,1,4'h0,2,16'h0,0,16'h0)); // idle bank ok
    add(0, C_REF, 0, 13'h000, 16'h0, 2'b00, mk(0,6,1,1,4'h0,2,16'h1,0,16'h0));
    add(0, C_REF, 0, 13'h000, 16'h0, 2'b00, mk(0,6,1,1,4'h0,2,16'h2,0,16'h0));
    add(0, C_REF, 0, 13'h000, 16'h0, 2'b00, mk(0,6,1,1,4'h0,2,16'h3,0,16'h0));
    add(0, C_ACT, 2, 13'h003, 16'h0, 2'b00, mk(0,6,1,1,4'h4,2,16'h3,0,16'h0));
    add(0, C_WR,  2, 13'h005, 16'hA5C3, 2'b00, mk(1,4,1,1,4'h4,2,16'h3,0,16'h0)); // tRCD
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,4,1,1,4'h4,2,16'h3,0,16'h0));
    add(0, C_PRE, 0, 13'h400, 16'h0, 2'b00, mk(0,4,1,1,4'h0,2,16'h3,0,16'h0));
    add(0, C_ACT, 2, 13'h003, 16'h0, 2'b00, mk(0,4,1,1,4'h4,2,16'h3,0,16'h0));
    add(0, C_RD,  2, 13'h005, 16'h0, 2'b00, mk(1,4,1,1,4'h4,2,16'h3,0,16'h0)); // tRCD
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,4,1,1,4'h4,2,16'h3,1,16'hA5C3));
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,4,1,1,4'h4,2,16'h3,0,16'h0));
    add(0, C_PRE, 0, 13'h400, 16'h0, 2'b00, mk(0,4,1,1,4'h0,2,16'h3,0,16'h0));
    add(0, C_LM,  0, 13'h030, 16'h0, 2'b00, mk(0,4,1,1,4'h0,3,16'h3,0,16'h0)); // CL3
    add(0, C_ACT, 1, 13'h005, 16'h0, 2'b00, mk(0,4,1,1,4'h2,3,16'h3,0,16'h0));
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,4,1,1,4'h2,3,16'h3,0,16'h0));
    for (int i = 0; i < 4; i++)
      add(0, C_WR, 1, 13'(i), 16'h1000 + 16'(i), 2'b00,
          mk(0,4,1,1,4'h2,3,16'h3,0,16'h0));
    add(0, C_RD,  1, 13'h000, 16'h0, 2'b11, mk(0,4,1,1,4'h2,3,16'h3,0,16'h0));
    add(0, C_RD,  1, 13'h001, 16'h0, 2'b11, mk(0,4,1,1,4'h2,3,16'h3,0,16'h0));
    add(0, C_RD,  1, 13'h002, 16'h0, 2'b11, mk(0,4,1,1,4'h2,3,16'h3,1,16'h1000));
    add(0, C_RD,  1, 13'h003, 16'h0, 2'b11, mk(0,4,1,1,4'h2,3,16'h3,1,16'h1001));
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,4,1,1,4'h2,3,16'h3,1,16'h1002));
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,4,1,1,4'h2,3,16'h3,1,16'h1003));
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,4,1,1,4'h2,3,16'h3,0,16'h0));
    add(0, C_RD,  1, 13'h001, 16'h0, 2'b00, mk(0,4,1,1,4'h2,3,16'h3,0,16'h0));
    add(0, C_PRE, 0, 13'h400, 16'h0, 2'b00, mk(0,4,1,1,4'h0,3,16'h3,0,16'h0)); // during latency
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,4,1,1,4'h0,3,16'h3,1,16'h1001));
    add(0, C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,4,1,1,4'h0,3,16'h3,0,16'h0));

    // ---------------- reset state ----------------
    reset = 1'b1;
    drive(1'b1, C_NOP, 2'd0, 13'h0, 16'h0, 2'b00);
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", sample(), mk(0,0,0,0,4'h0,3,16'h0,0,16'h0));
    reset = 1'b0;

    // ---------------- table ----------------
    foreach (vecs[i]) begin
      drive(vecs[i].ncs, vecs[i].cmd, vecs[i].ba, vecs[i].a, vecs[i].dq, vecs[i].dqm);
      @(posedge clk); #1;
      check($sformatf("vec%0d", i), sample(), vecs[i].exp);
    end

    // ---------------- reset in the middle of CL3 reads ----------------
    stepc("mr_act",  C_ACT, 1, 13'h005, 16'h0, 2'b00, mk(0,4,1,1,4'h2,3,16'h3,0,16'h0));
    stepc("mr_nop",  C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,4,1,1,4'h2,3,16'h3,0,16'h0));
    stepc("mr_rd0",  C_RD,  1, 13'h000, 16'h0, 2'b00, mk(0,4,1,1,4'h2,3,16'h3,0,16'h0));
    stepc("mr_rd1",  C_RD,  1, 13'h001, 16'h0, 2'b00, mk(0,4,1,1,4'h2,3,16'h3,0,16'h0));
    reset = 1'b1;
    drive(1'b0, C_NOP, 2'd0, 13'h0, 16'h0, 2'b00);
    @(posedge clk); #1;
    check("mr_reset", sample(), mk(0,0,0,0,4'h0,3,16'h0,0,16'h0));
    reset = 1'b0;
    for (int i = 0; i < 3; i++)
      stepc($sformatf("mr_quiet%0d", i), C_NOP, 0, 13'h000, 16'h0, 2'b00,
            mk(0,0,0,0,4'h0,3,16'h0,0,16'h0));

    // Re-init at CL2 and confirm storage survived reset.
    stepc("ri_pre", C_PRE, 0, 13'h400, 16'h0, 2'b00, mk(0,0,0,0,4'h0,3,16'h0,0,16'h0));
    stepc("ri_lm",  C_LM,  0, 13'h020, 16'h0, 2'b00, mk(0,0,0,1,4'h0,2,16'h0,0,16'h0));
    stepc("ri_act", C_ACT, 1, 13'h005, 16'h0, 2'b00, mk(0,0,0,1,4'h2,2,16'h0,0,16'h0));
    stepc("ri_nop", C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,0,0,1,4'h2,2,16'h0,0,16'h0));
    stepc("ri_rd2", C_RD,  1, 13'h002, 16'h0, 2'b00, mk(0,0,0,1,4'h2,2,16'h0,0,16'h0));
    stepc("ri_d2",  C_RD,  1, 13'h1A4, 16'h0, 2'b00, mk(0,0,0,1,4'h2,2,16'h0,1,16'h1002));
    stepc("ri_d1a4",C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,0,0,1,4'h2,2,16'h0,1,16'hBE77));
    stepc("ri_idle",C_NOP, 0, 13'h000, 16'h0, 2'b00, mk(0,0,0,1,4'h2,2,16'h0,0,16'h0));

    // ---------------- refresh counter wrap ----------------
    stepc("rw_pre", C_PRE, 0, 13'h400, 16'h0, 2'b00, mk(0,0,0,1,4'h0,2,16'h0,0,16'h0));
    drive(1'b0, C_REF, 2'd0, 13'h0, 16'h0, 2'b00);
    repeat (65534) @(posedge clk);
    #1;
    stepc("rw_ffff", C_REF, 0, 13'h000, 16'h0, 2'b00, mk(0,0,0,1,4'h0,2,16'hFFFF,0,16'h0));
    stepc("rw_wrap", C_REF, 0, 13'h000, 16'h0, 2'b00, mk(0,0,0,1,4'h0,2,16'h0000,0,16'h0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
